// File: rtl/hrange_pkg.sv
// Shared types and defaults for the range/duplicate stream generator.
package hrange_pkg;

  typedef enum logic {
    S_DONE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DUP   = 2;

endpackage

// File: rtl/hrange_step_unit.sv
// Combinational successor/termination logic: next element, and whether the
// sequence ends after the current element (overflow, bound reached, zero step).
module hrange_step_unit #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] i,
  input  logic signed [WIDTH-1:0] step,
  input  logic signed [WIDTH-1:0] limit,
  output logic signed [WIDTH-1:0] nxt,
  output logic                    last,
  output logic                    cur_ok
);

  logic [WIDTH:0] sum;
  logic           ovf;

  // Direction of the bound test follows the sign of the step.
  function automatic logic cont(input logic signed [WIDTH-1:0] x,
                                input logic signed [WIDTH-1:0] st,
                                input logic signed [WIDTH-1:0] lim);
    return st[WIDTH-1] ? (x > lim) : (x < lim);
  endfunction

  always_comb begin
    sum    = {i[WIDTH-1], i} + {step[WIDTH-1], step};
    ovf    = sum[WIDTH] ^ sum[WIDTH-1];
    nxt    = sum[WIDTH-1:0];
    last   = ovf | !cont(nxt, step, limit) | (step == '0);
    cur_ok = cont(i, step, limit);
  end

endmodule

// File: rtl/hrange_dup_gen.sv
// Streaming arithmetic-sequence generator; elements above a threshold are
// emitted DUP times, tagged with their copy index, under start/ready/valid/done.
module hrange_dup_gen
  import hrange_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DUP   = DEF_DUP,
  parameter int CW    = $clog2(DUP + 1)
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic signed [WIDTH-1:0] thresh,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic [CW-1:0]           _copy
);

  localparam int CW1 = CW + 1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] i_q, i_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic signed [WIDTH-1:0] limit_q, limit_d;
  logic signed [WIDTH-1:0] thresh_q, thresh_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]           rep_q, rep_d;
  logic [CW-1:0]           copy_q, copy_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    adv;
  logic [CW1-1:0]          ncopies;

  logic signed [WIDTH-1:0] su_i, su_step, su_limit, su_nxt;
  logic                    su_last, su_cur_ok;

  // One step unit serves both the start check (on the raw inputs) and the advance.
  assign su_i     = _start ? base  : i_q;
  assign su_step  = _start ? step  : step_q;
  assign su_limit = _start ? limit : limit_q;

  hrange_step_unit #(.WIDTH(WIDTH)) u_step (
    .i      (su_i),
    .step   (su_step),
    .limit  (su_limit),
    .nxt    (su_nxt),
    .last   (su_last),
    .cur_ok (su_cur_ok)
  );

  assign adv     = !valid_q || _ready;
  assign ncopies = (i_q > thresh_q) ? CW1'(DUP) : CW1'(1);

  always_comb begin
    // NOTE: every next-state signal is given its hold value first, so no branch can infer a latch.
    state_d  = state_q;
    i_d      = i_q;
    step_d   = step_q;
    limit_d  = limit_q;
    thresh_d = thresh_q;
    out_d    = out_q;
    rep_d    = rep_q;
    copy_d   = copy_q;
    valid_d  = valid_q;
    done_d   = done_q;

    if (_start) begin
      step_d   = step;
      limit_d  = limit;
      thresh_d = thresh;
      i_d      = base;
      rep_d    = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      state_d  = (!su_cur_ok || step == '0) ? S_DONE : S_EMIT;
    end else if (adv) begin
      unique case (state_q)
        S_EMIT: begin
          out_d   = i_q;
          copy_d  = rep_q;
          valid_d = 1'b1;
          if (({1'b0, rep_q} + CW1'(1)) < ncopies) begin
            rep_d = rep_q + CW'(1);
          end else begin
            rep_d = '0;
            if (su_last) state_d = S_DONE;
            else         i_d     = su_nxt;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous, so it sits in the sensitivity list.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q  <= S_DONE;
      i_q      <= '0;
      step_q   <= '0;
      limit_q  <= '0;
      thresh_q <= '0;
      out_q    <= '0;
      rep_q    <= '0;
      copy_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      step_q   <= step_d;
      limit_q  <= limit_d;
      thresh_q <= thresh_d;
      out_q    <= out_d;
      rep_q    <= rep_d;
      copy_q   <= copy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = out_q;
  assign _copy  = copy_q;

endmodule

// File: tb/tb_hrange_dup_gen.sv
// Scoreboard bench for hrange_dup_gen: a 32-bit/DUP=2 and an 8-bit/DUP=3 instance
// checked against a sequence model computed with plain integer arithmetic.
module tb_hrange_dup_gen;

  typedef struct {
    longint v;
    int     c;
  } beat_t;

  logic clk;
  logic rst;

  logic signed [31:0] b32, l32, s32, t32, o32;
  logic               st32, rd32, v32, d32;
  logic [1:0]         c32;

  logic signed [7:0]  b8, l8, s8, t8, o8;
  logic               st8, rd8, v8, d8;
  logic [1:0]         c8;

  beat_t  q32[$];
  beat_t  q8[$];
  int     checks = 0;
  int     errors = 0;
  bit     hold_f[2];
  longint hold_o[2];
  int     hold_c[2];

  hrange_dup_gen #(.WIDTH(32), .DUP(2)) dut32 (
    ._clock(clk), ._reset(rst), ._start(st32),
    .base(b32), .limit(l32), .step(s32), .thresh(t32),
    ._ready(rd32), ._valid(v32), ._done(d32), ._0(o32), ._copy(c32)
  );

  hrange_dup_gen #(.WIDTH(8), .DUP(3)) dut8 (
    ._clock(clk), ._reset(rst), ._start(st8),
    .base(b8), .limit(l8), .step(s8), .thresh(t8),
    ._ready(rd8), ._valid(v8), ._done(d8), ._0(o8), ._copy(c8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic get_valid(int k);  return k ? v8 : v32; endfunction
  function automatic logic get_done(int k);   return k ? d8 : d32; endfunction
  function automatic logic get_ready(int k);  return k ? rd8 : rd32; endfunction
  function automatic logic get_start(int k);  return k ? st8 : st32; endfunction
  function automatic longint get_out(int k);  return k ? longint'(o8) : longint'(o32); endfunction
  function automatic int get_copy(int k);     return k ? int'(c8) : int'(c32); endfunction
  function automatic int qsize(int k);        return k ? q8.size() : q32.size(); endfunction

  task automatic set_ready(int k, logic r);
    if (k != 0) rd8 = r; else rd32 = r;
  endtask

  task automatic set_start(int k, logic s);
    if (k != 0) st8 = s; else st32 = s;
  endtask

  task automatic drive(int k, longint b, longint l, longint s, longint t);
    if (k != 0) begin
      b8 = b[7:0];  l8 = l[7:0];  s8 = s[7:0];  t8 = t[7:0];
    end else begin
      b32 = b[31:0]; l32 = l[31:0]; s32 = s[31:0]; t32 = t[31:0];
    end
  endtask

  // Reference: walk the sequence with wide integers; stop when the bound is
  // reached or the next value no longer fits the signed width.
  task automatic model(int k, longint b, longint l, longint s, longint t);
    int     width = k ? 8 : 32;
    int     dup   = k ? 3 : 2;
    longint maxv  = (longint'(1) <<< (width - 1)) - 1;
    longint minv  = -(longint'(1) <<< (width - 1));
    longint x     = b;
    int     n     = 0;
    beat_t  e;
    if (k != 0) q8.delete(); else q32.delete();
    if (s == 0) return;
    while ((s > 0) ? (x < l) : (x > l)) begin
      for (int c = 0; c < ((x > t) ? dup : 1); c++) begin
        e.v = x;
        e.c = c;
        if (k != 0) q8.push_back(e); else q32.push_back(e);
      end
      x = x + s;
      n++;
      if (x > maxv || x < minv || n > 4000) break;
    end
  endtask

  // Monitor: pops on each accepted beat, and checks that a stalled beat holds.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hold_f[k] = 1'b0;
      end else begin
        if (hold_f[k]) begin
          check("hold_valid", longint'(get_valid(k)), 1);
          check("hold_out", get_out(k), hold_o[k]);
          check("hold_copy", get_copy(k), hold_c[k]);
        end
        hold_f[k] = 1'b0;
        if (!get_start(k) && get_valid(k)) begin
          if (get_ready(k)) begin
            if (qsize(k) == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat dut%0d actual=%0d/%0d expected=none",
                       k, get_out(k), get_copy(k));
            end else begin
              beat_t e;
              if (k != 0) e = q8.pop_front(); else e = q32.pop_front();
              check(k ? "beat8_value" : "beat32_value", get_out(k), e.v);
              check(k ? "beat8_copy" : "beat32_copy", get_copy(k), e.c);
            end
          end else begin
            hold_f[k] = 1'b1;
            hold_o[k] = get_out(k);
            hold_c[k] = get_copy(k);
          end
        end
      end
    end
  end

  task automatic launch(int k, longint b, longint l, longint s, longint t);
    @(posedge clk); #1;
    model(k, b, l, s, t);
    drive(k, b, l, s, t);
    set_ready(k, 1'b1);
    set_start(k, 1'b1);
    @(posedge clk); #1;
    set_start(k, 1'b0);
  endtask

  // mode 0: ready held high; 1: random ready; 2: stall 3 cycles on beat (6, copy 0)
  task automatic run(int k, longint b, longint l, longint s, longint t, int mode, string name);
    int stalls   = 0;
    bit finished = 1'b0;
    launch(k, b, l, s, t);
    check({name, "_capture_done"}, longint'(get_done(k)), 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      case (mode)
        1: set_ready(k, $urandom_range(0, 3) != 0);
        2: begin
          if (get_valid(k) && get_out(k) == 6 && get_copy(k) == 0 && stalls < 3) begin
            set_ready(k, 1'b0);
            stalls++;
          end else begin
            set_ready(k, 1'b1);
          end
        end
        default: set_ready(k, 1'b1);
      endcase
      @(posedge clk); #1;
      if (get_done(k) && !get_valid(k)) begin
        finished = 1'b1;
        break;
      end
    end
    set_ready(k, 1'b1);
    check({name, "_finished"}, longint'(finished), 1);
    check({name, "_drained"}, qsize(k), 0);
  endtask

  task automatic check_empty(int k, longint b, longint l, longint s, longint t, string name);
    launch(k, b, l, s, t);
    check({name, "_done_low"}, longint'(get_done(k)), 0);
    check({name, "_no_valid0"}, longint'(get_valid(k)), 0);
    @(posedge clk); #1;
    check({name, "_done_high"}, longint'(get_done(k)), 1);
    check({name, "_no_valid1"}, longint'(get_valid(k)), 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_no_valid2"}, longint'(get_valid(k)), 0);
  endtask

  initial begin
    rst = 1'b1;
    st32 = 1'b0; rd32 = 1'b1; b32 = '0; l32 = '0; s32 = '0; t32 = '0;
    st8  = 1'b0; rd8  = 1'b1; b8  = '0; l8  = '0; s8  = '0; t8  = '0;
    #3;
    check("rst_valid", longint'(v32), 0);
    check("rst_done", longint'(d32), 1);
    check("rst_out", longint'(o32), 0);
    check("rst_copy", longint'(c32), 0);
    check("rst_valid8", longint'(v8), 0);
    check("rst_done8", longint'(d8), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    run(0, 0, 10, 2, 4, 0, "inc_dup");
    run(0, 10, 0, -3, 100, 0, "dec");
    check_empty(0, 0, 10, 0, 0, "zero_step");
    check_empty(0, 5, 5, 1, 0, "empty_range");
    run(1, 120, 127, 5, -128, 0, "ovf8");
    run(1, -120, -128, -5, 127, 0, "ovf8_neg");
    run(0, 64'sd2147483640, 64'sd2147483647, 4, 0, 0, "ovf32");
    run(0, 0, 10, 2, 4, 2, "backpressure");

    // Restart mid-stream: the new run discards whatever was pending.
    launch(0, 0, 10, 2, 4);
    repeat (3) @(posedge clk);
    run(0, 10, 0, -3, 100, 0, "restart");

    // Asynchronous reset in the middle of a stream.
    launch(0, 0, 10, 2, 4);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", longint'(v32), 0);
    check("async_rst_done", longint'(d32), 1);
    q32.delete();
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run(0, 1, 11, 3, 4, 0, "post_reset");

    for (int n = 0; n < 10; n++) begin
      longint b, l, s, t;
      b = longint'($urandom_range(0, 400)) - 200;
      s = longint'($urandom_range(1, 9));
      if ($urandom_range(0, 1) != 0) s = -s;
      l = b + s * (longint'($urandom_range(0, 40)) - 5) + longint'($urandom_range(0, 2)) - 1;
      t = b + longint'($urandom_range(0, 100)) - 50;
      run(0, b, l, s, t, 1, "rand32");
    end

    for (int n = 0; n < 10; n++) begin
      longint b, l, s, t;
      b = longint'($urandom_range(0, 255)) - 128;
      l = longint'($urandom_range(0, 255)) - 128;
      t = longint'($urandom_range(0, 255)) - 128;
      s = longint'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 3 : 60));
      if ($urandom_range(0, 1) != 0) s = -s;
      run(1, b, l, s, t, 1, "rand8");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
